// File: rtl/power3_sched_if.sv
// power3_sched_if: requester, result and status signals
// of the shared cube engine.
interface power3_sched_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_x;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_x;
    logic             req1_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_ready;
    logic             busy;

    modport master (
        output req0_valid, req0_x,
        output req1_valid, req1_x,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_id,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_x,
        input  req1_valid, req1_x,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_id,
        output busy
    );
endinterface

// File: rtl/power3_sched.sv
// power3_sched: two-port round-robin scheduler around one
// iterative multiplier computing x^3 mod 2^WIDTH.
module power3_sched #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    power3_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SQ,
        CUBE,
        HOLD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] res_data_q;
    logic             res_valid_q;
    logic             res_id_q;
    logic             id_reg;
    logic             last_id;
    logic             busy_q;

    logic             grant0;
    logic             grant1;
    logic             open_q;
    logic             take0;
    logic             take1;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] prod;

    // Round-robin pick: a lone requester always wins,
    // contention goes to the one not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.req0_valid && (!bus.req1_valid || last_id))
            grant0 = 1'b1;
        else if (bus.req1_valid)
            grant1 = 1'b1;
    end

    assign open_q = (state == IDLE) && !rst;
    assign bus.req0_ready = open_q && grant0;
    assign bus.req1_ready = open_q && grant1;
    assign take0 = bus.req0_ready && bus.req0_valid;
    assign take1 = bus.req1_ready && bus.req1_valid;

    // Single shared multiplier: x*x in SQ, acc*x in CUBE.
    assign op_a = (state == CUBE) ? acc : x_reg;
    assign prod = op_a * x_reg;

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = busy_q;

    // Sequencer: accept, square, cube, then hold the
    // result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            x_reg       <= '0;
            acc         <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            id_reg      <= 1'b0;
            last_id     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take0 || take1) begin
                        x_reg   <= take1 ? bus.req1_x
                                         : bus.req0_x;
                        id_reg  <= take1;
                        last_id <= take1;
                        busy_q  <= 1'b1;
                        state   <= SQ;
                    end
                end
                SQ: begin
                    acc   <= prod;
                    state <= CUBE;
                end
                CUBE: begin
                    res_data_q  <= prod;
                    res_id_q    <= id_reg;
                    res_valid_q <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_power3_sched.sv
// tb_power3_sched: directed and randomized checks of
// power3_sched against an arithmetic cube model.
module tb_power3_sched;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    power3_sched_if #(.WIDTH(W)) bus ();

    power3_sched #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    function automatic logic [7:0] cube(input logic [7:0] x);
        logic [31:0] v;
        v = {24'd0, x};
        v = v * v * v;
        return v[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_x     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_x     = '0;
        bus.res_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic serve(input logic id, input logic [7:0] x,
                         input logic [7:0] exp,
                         input string tag);
        int n;
        bus.res_ready = 1'b1;
        if (id) begin
            bus.req1_valid = 1'b1;
            bus.req1_x     = x;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_x     = x;
        end
        #1;
        n = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready)
               && n < 20) begin
            tick();
            #1;
            n++;
        end
        check({tag, "_accept"}, n < 20, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_data"}, bus.res_data, exp);
        check({tag, "_id"}, bus.res_id, id);
        tick();
    endtask

    initial begin
        logic [7:0] q0[$];
        logic [7:0] q1[$];
        logic [7:0] nx0;
        logic [7:0] nx1;
        logic [7:0] e;
        logic       a0;
        logic       a1;
        logic       r0;
        logic       r1;
        logic       last_acc;
        int         n;
        int         got;
        int         exp_id;
        int         cyc;
        int         sent0;
        int         sent1;
        int         acc_cnt;
        int         resp_cnt;

        // reset state, with both valids up
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        tick();
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        check("rst_valid", bus.res_valid, 0);
        check("rst_data", bus.res_data, 0);
        check("rst_id", bus.res_id, 0);
        check("rst_busy", bus.busy, 0);
        idle_inputs();
        rst = 1'b0;
        tick();

        // first request, cycle by cycle
        bus.req0_valid = 1'b1;
        bus.req0_x     = 8'd3;
        bus.res_ready  = 1'b1;
        #1;
        check("x3_ready0", bus.req0_ready, 1);
        check("x3_ready1", bus.req1_ready, 0);
        check("x3_busy0", bus.busy, 0);
        tick();
        bus.req0_valid = 1'b0;
        check("x3_busy1", bus.busy, 1);
        check("x3_rv1", bus.res_valid, 0);
        tick();
        check("x3_busy2", bus.busy, 1);
        check("x3_rv2", bus.res_valid, 0);
        tick();
        check("x3_busy3", bus.busy, 1);
        check("x3_rv3", bus.res_valid, 1);
        check("x3_data", bus.res_data, 27);
        check("x3_id", bus.res_id, 0);
        tick();
        check("x3_busy4", bus.busy, 0);
        check("x3_rv4", bus.res_valid, 0);
        check("x3_keep", bus.res_data, 27);

        // width wrap
        serve(1'b0, 8'd7, 8'd87, "w7");
        serve(1'b1, 8'd255, 8'd255, "w255");
        serve(1'b0, 8'd16, 8'd0, "w16");
        serve(1'b1, 8'd0, 8'd0, "w0");
        serve(1'b0, 8'd1, 8'd1, "w1");

        // contention from reset: strict alternation
        do_reset();
        nx0 = 8'd2;
        nx1 = 8'd5;
        bus.req0_x     = nx0;
        bus.req1_x     = nx1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready  = 1'b1;
        got = 0;
        exp_id = 0;
        cyc = 0;
        while (got < 6 && cyc < 100) begin
            #1;
            if (bus.res_valid && bus.res_ready) begin
                check("cont_id", bus.res_id, exp_id);
                if (bus.res_id) begin
                    if (q1.size() == 0) check("cont_extra", 1, 0);
                    else check("cont_data1", bus.res_data,
                               q1.pop_front());
                end else begin
                    if (q0.size() == 0) check("cont_extra", 1, 0);
                    else check("cont_data0", bus.res_data,
                               q0.pop_front());
                end
                exp_id = 1 - exp_id;
                got++;
            end
            a0 = bus.req0_ready;
            a1 = bus.req1_ready;
            tick();
            if (a0) begin
                q0.push_back(cube(nx0));
                nx0++;
                bus.req0_x = nx0;
            end
            if (a1) begin
                q1.push_back(cube(nx1));
                nx1++;
                bus.req1_x = nx1;
            end
            cyc++;
        end
        check("cont_count", got, 6);
        idle_inputs();
        q0.delete();
        q1.delete();
        tick();
        tick();
        tick();
        tick();

        // back-pressure
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_x     = 8'd3;
        #1;
        check("bp_ready0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_x     = 8'd9;
        n = 0;
        while (!bus.res_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_wait", n < 20, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", bus.res_valid, 1);
            check("bp_data", bus.res_data, 27);
            check("bp_id", bus.res_id, 0);
            check("bp_rdy0", bus.req0_ready, 0);
            check("bp_rdy1", bus.req1_ready, 0);
            tick();
        end
        bus.res_ready = 1'b1;
        #1;
        check("bp_hs_rdy1", bus.req1_ready, 0);
        tick();
        #1;
        check("bp_after_rv", bus.res_valid, 0);
        check("bp_after_busy", bus.busy, 0);
        check("bp_next_rdy1", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        check("bp_next_busy", bus.busy, 1);
        n = 0;
        while (!bus.res_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_next_data", bus.res_data, 217);
        check("bp_next_id", bus.res_id, 1);
        tick();

        // reset while in CUBE
        do_reset();
        bus.req1_valid = 1'b1;
        bus.req1_x     = 8'd4;
        bus.res_ready  = 1'b1;
        #1;
        check("mid_ready1", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        check("mid_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        check("mid_rv", bus.res_valid, 0);
        check("mid_data", bus.res_data, 0);
        check("mid_id", bus.res_id, 0);
        check("mid_busy0", bus.busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_norv", bus.res_valid, 0);
        end
        serve(1'b0, 8'd2, 8'd8, "mid_after");

        // randomized traffic against the queue model
        do_reset();
        last_acc = 1'b1;
        sent0 = 0;
        sent1 = 0;
        acc_cnt = 0;
        resp_cnt = 0;
        cyc = 0;
        while ((acc_cnt < 1000 || q0.size() + q1.size() > 0
                || bus.res_valid) && cyc < 40000) begin
            if (!bus.req0_valid && sent0 < 500
                && $urandom_range(0, 3) == 0) begin
                bus.req0_valid = 1'b1;
                bus.req0_x     = 8'($urandom);
                sent0++;
            end
            if (!bus.req1_valid && sent1 < 500
                && $urandom_range(0, 3) == 0) begin
                bus.req1_valid = 1'b1;
                bus.req1_x     = 8'($urandom);
                sent1++;
            end
            bus.res_ready = (acc_cnt >= 1000) ? 1'b1
                          : ($urandom_range(0, 2) != 0);
            #1;
            r0 = bus.req0_ready;
            r1 = bus.req1_ready;
            a0 = r0 && bus.req0_valid;
            a1 = r1 && bus.req1_valid;
            check("rnd_excl", r0 && r1, 0);
            check("rnd_hold", (r0 || r1) && bus.res_valid, 0);
            if (a0 || a1) begin
                if (bus.req0_valid && bus.req1_valid)
                    check("rnd_fair", a1, !last_acc);
                last_acc = a1;
                if (a0) q0.push_back(cube(bus.req0_x));
                if (a1) q1.push_back(cube(bus.req1_x));
                acc_cnt++;
            end
            if (bus.res_valid && bus.res_ready) begin
                if (bus.res_id) begin
                    if (q1.size() == 0) check("rnd_extra1", 1, 0);
                    else begin
                        e = q1.pop_front();
                        check("rnd_data1", bus.res_data, e);
                    end
                end else begin
                    if (q0.size() == 0) check("rnd_extra0", 1, 0);
                    else begin
                        e = q0.pop_front();
                        check("rnd_data0", bus.res_data, e);
                    end
                end
                resp_cnt++;
            end
            tick();
            if (a0) bus.req0_valid = 1'b0;
            if (a1) bus.req1_valid = 1'b0;
            cyc++;
        end
        check("rnd_timeout", cyc < 40000, 1);
        check("rnd_accepts", acc_cnt, 1000);
        check("rnd_responses", resp_cnt, 1000);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/power3_sched.md
# power3_sched

Shared-engine scheduler for cube computation. Two requesters submit WIDTH-bit operands through valid/ready handshakes. A round-robin arbiter grants one request at a time to a single iterative multiplier, which computes X³ mod 2^WIDTH in two multiply steps. The result is returned with the requester's ID. The block trades the fully pipelined cube datapath's throughput for one multiplier instance, for use where cube requests are sparse.

## Interface
- WIDTH, 8, operand/result width; all arithmetic is mod 2^WIDTH
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand
- req0_x  in  WIDTH  requester 0 operand
- req0_ready  out  1  requester 0 operand accepted this cycle when high with req0_valid
- req1_valid  in  1  requester 1 has an operand
- req1_x  in  WIDTH  requester 1 operand
- req1_ready  out  1  requester 1 operand accepted this cycle when high with req1_valid
- res_valid  out  1  result available
- res_data  out  WIDTH  X³ mod 2^WIDTH
- res_id  out  1  requester that owns res_data
- res_ready  in  1  consumer accepts result
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states:
  - IDLE → SQ on an accepted request.
  - SQ → CUBE unconditionally.
  - CUBE → HOLD unconditionally.
  - HOLD → IDLE on res_valid & res_ready.
- Acceptance (IDLE only):
  - Grant goes to one requester.
  - If only one valid: grant it.
  - If both valid: grant the requester ≠ last_id.
  - reqN_ready = (state==IDLE) & grant==N & !rst. It may depend combinationally on the valids.
  - The non-granted ready is 0.
- On accept: latch x_reg ← reqN_x, id_reg ← N, last_id ← N.
- SQ: acc ← (x_reg × x_reg)[WIDTH-1:0].
- CUBE: res_data ← (acc × x_reg)[WIDTH-1:0], res_id ← id_reg, res_valid ← 1.
- HOLD: res_valid, res_data and res_id are held stable until res_ready. On handshake, res_valid ← 0. res_data/res_id keep their last values.
- One multiplier instance total. Both multiply steps use it, with muxed operands.
- Requester rules: valid and x must be held until accepted. Valid must never depend on ready. A request that drops valid before acceptance is not served.
- Reset values: state IDLE, res_valid 0, res_data 0, res_id 0, busy 0, last_id 1 (requester 0 wins the first contention), x_reg/acc 0, both readys 0.
- Reset mid-operation: abandon the in-flight request; no result is emitted and requesters are not notified. Reset wins over a simultaneous handshake.

## Timing
- Accept at edge N → SQ at N; acc valid at N+1; res_valid=1 from edge N+2.
- Minimum latency from accept to result visible: 2 cycles. Handshake is possible in the first HOLD cycle.
- res_valid & res_ready at edge M → IDLE. The next accept happens no earlier than edge M+1 (no bypass from HOLD).
- Peak throughput: 1 result per 4 cycles with res_ready tied high.
- busy rises the cycle after accept and falls the cycle after the result handshake.
- Back-pressure: res_ready low holds HOLD indefinitely. Both readys stay 0 throughout.
- Both requesters continuously valid: grants strictly alternate 0,1,0,1…
- A single requester continuously valid is served every 4 cycles; fairness does not block it.

## Test plan
- Reset, then req0 x=3 with res_ready=1 → req0_ready high 1 cycle; res_valid 2 cycles later with res_data=27, res_id=0; busy high 3 cycles.
- Width wrap: x=7 → 87 (343 mod 256); x=255 → 255; x=16 → 0; x=0 → 0; x=1 → 1.
- Contention from reset, both valid (req0 x=2, req1 x=5) → req0 served first (8, id 0), then req1 (125, id 1). Continued contention alternates IDs.
- Back-pressure: res_ready low 5 cycles after res_valid → res_data/res_id stable, both readys 0. The handshake on the 6th cycle returns to IDLE; the next accept is one cycle later.
- Reset asserted in CUBE with req1 x=4 in flight → no res_valid; post-reset outputs all 0. A subsequent req0 x=2 yields 8, id 0.
- Random: 1000 operands on both ports, random valid gaps and random res_ready → each result equals x³ mod 256 in per-requester order. No request is lost or duplicated, and the response count matches the accept count.
